// File: rtl/router_out_arbiter.sv
// Round-robin drain of three router FIFOs onto one egress byte stream.
// Forwards whole packets, checks parity, aborts on stall or soft reset.
module router_out_arbiter #(
  parameter int TIMEOUT_CYC = 30,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] dout_0,
  input  logic [7:0] dout_1,
  input  logic [7:0] dout_2,
  input  logic       soft_rst_0,
  input  logic       soft_rst_1,
  input  logic       soft_rst_2,
  input  logic       out_ready,
  output logic       rd_en_0,
  output logic       rd_en_1,
  output logic       rd_en_2,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_port,
  output logic       par_err,
  output logic       pkt_abort
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] PAY  = 2'd2;
  localparam logic [1:0] PAR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       last_q, last_d;
  logic             rd_q;
  logic [5:0]       len_q, len_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       acc_q, acc_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic             perr_q, perr_d;
  logic             abt_q, abt_d;

  logic [2:0] req;
  logic [1:0] pick;
  logic       req_g;
  logic       srst_g;
  logic [7:0] din;
  logic       active;
  logic       body;
  logic       slot;
  logic       rd;
  logic       land;
  logic       inc;
  logic       tmo;
  logic       abort;

  assign req = {vld_out_2, vld_out_1, vld_out_0};

  // First requester after the last granted port, wrapping 0->1->2->0.
  always_comb begin
    pick = last_q;
    unique case (last_q)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    req_g  = 1'b0;
    srst_g = 1'b0;
    din    = '0;
    unique case (gnt_q)
      2'd1: begin
        req_g  = vld_out_1;
        srst_g = soft_rst_1;
        din    = dout_1;
      end
      2'd2: begin
        req_g  = vld_out_2;
        srst_g = soft_rst_2;
        din    = dout_2;
      end
      default: begin
        req_g  = vld_out_0;
        srst_g = soft_rst_0;
        din    = dout_0;
      end
    endcase
  end

  assign active = (state_q != IDLE);
  assign body   = (state_q == PAY) || (state_q == PAR);
  assign slot   = !vld_q || out_ready;
  assign inc    = body && !req_g;
  assign tmo    = inc && (to_q == CNT_W'(TIMEOUT_CYC - 1));
  assign abort  = active && (srst_g || tmo);
  assign rd     = active && req_g && !rd_q && slot && !abort;
  assign land   = rd_q && active;

  assign rd_en_0 = rd && (gnt_q == 2'd0);
  assign rd_en_1 = rd && (gnt_q == 2'd1);
  assign rd_en_2 = rd && (gnt_q == 2'd2);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    vld_d   = vld_q && !out_ready;
    sop_d   = sop_q;
    eop_d   = eop_q;
    perr_d  = 1'b0;
    abt_d   = 1'b0;
    to_d    = to_q;
    if (rd || !body) begin
      to_d = '0;
    end else if (inc) begin
      to_d = to_q + 1'b1;
    end
    // An abort drops the byte in flight and the byte on the output.
    if (abort) begin
      state_d = IDLE;
      last_d  = gnt_q;
      abt_d   = 1'b1;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_d   = pick;
            state_d = HDR;
          end
        end
        HDR: begin
          if (land) begin
            len_d   = din[7:2];
            acc_d   = din;
            cnt_d   = '0;
            state_d = (din[7:2] == 6'd0) ? PAR : PAY;
            data_d  = din;
            vld_d   = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end
        end
        PAY: begin
          if (land) begin
            acc_d  = acc_q ^ din;
            cnt_d  = cnt_q + 6'd1;
            data_d = din;
            vld_d  = 1'b1;
            sop_d  = 1'b0;
            eop_d  = 1'b0;
            if (cnt_d == len_q) begin
              state_d = PAR;
            end
          end
        end
        default: begin
          if (land) begin
            perr_d  = (din != acc_q);
            last_d  = gnt_q;
            state_d = IDLE;
            data_d  = din;
            vld_d   = 1'b1;
            sop_d   = 1'b0;
            eop_d   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      rd_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      perr_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rd_q    <= rd;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      to_q    <= to_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      perr_q  <= perr_d;
      abt_q   <= abt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_port  = gnt_q;
  assign par_err   = perr_q;
  assign pkt_abort = abt_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter with FIFO models and an
// egress monitor; expected streams are written out by hand.
module tb_router_out_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vld_out_0 = 1'b0;
  logic       vld_out_1 = 1'b0;
  logic       vld_out_2 = 1'b0;
  logic [7:0] dout_0 = '0;
  logic [7:0] dout_1 = '0;
  logic [7:0] dout_2 = '0;
  logic       soft_rst_0 = 1'b0;
  logic       soft_rst_1 = 1'b0;
  logic       soft_rst_2 = 1'b0;
  logic       out_ready = 1'b1;
  logic       rd_en_0, rd_en_1, rd_en_2;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop;
  logic [1:0] out_port;
  logic       par_err, pkt_abort;

  router_out_arbiter dut (
    .clk(clk), .rst(rst),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2),
    .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
    .soft_rst_2(soft_rst_2), .out_ready(out_ready),
    .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
    .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
    .par_err(par_err), .pkt_abort(pkt_abort)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  fq0[$];
  logic [7:0]  fq1[$];
  logic [7:0]  fq2[$];
  logic [10:0] eg_q[$];
  logic [10:0] exp_q[$];
  int          rd1_cyc[$];
  int eop_n = 0, perr_n = 0, perr_eop = 0, ab_n = 0, ab_cyc = 0;
  int rd_tot = 0, rd0_n = 0, rd0_last = 0;
  logic ab_ov = 1'b0;

  // FIFO models: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_0 && fq0.size() > 0) dout_0 <= fq0.pop_front();
    if (rd_en_1 && fq1.size() > 0) dout_1 <= fq1.pop_front();
    if (rd_en_2 && fq2.size() > 0) dout_2 <= fq2.pop_front();
  end

  always @(negedge clk) begin
    vld_out_0 = (fq0.size() != 0);
    vld_out_1 = (fq1.size() != 0);
    vld_out_2 = (fq2.size() != 0);
    if (out_valid && out_ready) begin
      eg_q.push_back({out_port, out_sop, out_eop, out_data});
      if (out_eop) eop_n++;
    end
    if (par_err) begin
      perr_n++;
      if (out_valid && out_eop) perr_eop++;
    end
    if (pkt_abort) begin
      ab_n++;
      ab_cyc = cyc;
      ab_ov  = out_valid;
    end
    if (rd_en_0 || rd_en_1 || rd_en_2) rd_tot++;
    if (rd_en_0) begin
      rd0_n++;
      rd0_last = cyc;
    end
    if (rd_en_1) rd1_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input logic [7:0] b);
    case (p)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  task automatic pkt1(input int p, input logic [7:0] h, input logic [7:0] d);
    push(p, h);
    push(p, d);
    push(p, h ^ d);
  endtask

  task automatic expb(input int p, input logic s, input logic e,
                      input logic [7:0] d);
    logic [1:0] pp;
    pp = p[1:0];
    exp_q.push_back({pp, s, e, d});
  endtask

  task automatic cmp_stream(input string tag, input int base);
    int n;
    n = eg_q.size() - base;
    chk({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), eg_q[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic wait_eop(input int target, input string tag);
    int k;
    k = 0;
    while (eop_n < target && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (eop_n < target) chk({tag, "_tmo"}, eop_n, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e0, p0, pe0, a0, r0, r1, snap, k, s;

    // Reset with all three FIFOs requesting, then fairness.
    repeat (3) @(posedge clk);
    #1;
    pkt1(0, 8'h04, 8'h10);
    pkt1(1, 8'h05, 8'h20);
    pkt1(2, 8'h06, 8'h30);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", {29'd0, rd_en_2, rd_en_1, rd_en_0}, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_pulse", {30'd0, par_err, pkt_abort}, 0);
    chk("rst_port", out_port, 0);
    base = eg_q.size();
    e0 = eop_n;
    rst = 1'b1;
    k = 0;
    while (out_port != 2'd1 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (out_port != 2'd1) chk("fair_p1_tmo", out_port, 1);
    pkt1(0, 8'h04, 8'h40);
    wait_eop(e0 + 4, "fair");
    expb(0, 1, 0, 8'h04); expb(0, 0, 0, 8'h10); expb(0, 0, 1, 8'h14);
    expb(1, 1, 0, 8'h05); expb(1, 0, 0, 8'h20); expb(1, 0, 1, 8'h25);
    expb(2, 1, 0, 8'h06); expb(2, 0, 0, 8'h30); expb(2, 0, 1, 8'h36);
    expb(0, 1, 0, 8'h04); expb(0, 0, 0, 8'h40); expb(0, 0, 1, 8'h44);
    cmp_stream("fair", base);

    // Single packet on port 1, good parity.
    repeat (4) @(posedge clk);
    #1;
    base = eg_q.size();
    e0 = eop_n;
    pe0 = perr_n;
    r1 = rd1_cyc.size();
    push(1, 8'h09); push(1, 8'hA5); push(1, 8'h3C); push(1, 8'h90);
    wait_eop(e0 + 1, "p1");
    expb(1, 1, 0, 8'h09); expb(1, 0, 0, 8'hA5);
    expb(1, 0, 0, 8'h3C); expb(1, 0, 1, 8'h90);
    cmp_stream("p1", base);
    chk("p1_perr", perr_n - pe0, 0);
    chk("p1_nrd", rd1_cyc.size() - r1, 4);
    if (rd1_cyc.size() >= r1 + 4)
      for (int i = 0; i < 3; i++)
        chk($sformatf("p1_gap%0d", i),
            rd1_cyc[r1 + i + 1] - rd1_cyc[r1 + i], 2);

    // Backpressure mid-payload on port 2.
    repeat (4) @(posedge clk);
    #1;
    base = eg_q.size();
    e0 = eop_n;
    push(2, 8'h0E); push(2, 8'h11); push(2, 8'h22);
    push(2, 8'h33); push(2, 8'h0E);
    k = 0;
    while (!(out_valid && out_data == 8'h11) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) chk("bp_find_tmo", out_data, 8'h11);
    @(posedge clk); #1;
    out_ready = 1'b0;
    snap = rd_tot;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_d", out_data, 8'h22);
    end
    @(posedge clk); #1;
    chk("bp_no_rd", rd_tot - snap, 0);
    out_ready = 1'b1;
    wait_eop(e0 + 1, "bp");
    expb(2, 1, 0, 8'h0E); expb(2, 0, 0, 8'h11); expb(2, 0, 0, 8'h22);
    expb(2, 0, 0, 8'h33); expb(2, 0, 1, 8'h0E);
    cmp_stream("bp", base);

    // Parity error on port 1.
    repeat (4) @(posedge clk);
    #1;
    base = eg_q.size();
    e0 = eop_n;
    pe0 = perr_n;
    p0 = perr_eop;
    push(1, 8'h09); push(1, 8'hA5); push(1, 8'h3C); push(1, 8'h91);
    wait_eop(e0 + 1, "pe");
    @(posedge clk); #1;
    expb(1, 1, 0, 8'h09); expb(1, 0, 0, 8'hA5);
    expb(1, 0, 0, 8'h3C); expb(1, 0, 1, 8'h91);
    cmp_stream("pe", base);
    chk("pe_cnt", perr_n - pe0, 1);
    chk("pe_with_eop", perr_eop - p0, 1);

    // Stall: header says 3 payload bytes, only one ever arrives.
    repeat (4) @(posedge clk);
    #1;
    base = eg_q.size();
    pe0 = perr_n;
    a0 = ab_n;
    push(0, 8'h0C); push(0, 8'h55);
    k = 0;
    while (ab_n == a0 && k < 120) begin
      @(posedge clk); #1;
      k++;
    end
    chk("tmo_abort_n", ab_n - a0, 1);
    chk("tmo_gap", ab_cyc - rd0_last - 1, 30);
    chk("tmo_ov", ab_ov, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("tmo_ov_after", out_valid, 0);
    chk("tmo_abort_once", ab_n - a0, 1);
    chk("tmo_perr", perr_n - pe0, 0);
    expb(0, 1, 0, 8'h0C); expb(0, 0, 0, 8'h55);
    cmp_stream("tmo", base);

    // Soft reset of port 0 mid-payload while port 1 waits.
    repeat (4) @(posedge clk);
    #1;
    base = eg_q.size();
    e0 = eop_n;
    pe0 = perr_n;
    a0 = ab_n;
    r0 = rd0_n;
    push(0, 8'h0C); push(0, 8'hA1); push(0, 8'hA2);
    push(0, 8'hA3); push(0, 8'hAC);
    k = 0;
    while (rd0_n < r0 + 2 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (rd0_n < r0 + 2) chk("sr_rd_tmo", rd0_n - r0, 2);
    pkt1(1, 8'h05, 8'h77);
    @(posedge clk); #1;
    s = cyc;
    soft_rst_0 = 1'b1;
    fq0.delete();
    @(posedge clk); #1;
    soft_rst_0 = 1'b0;
    wait_eop(e0 + 1, "sr");
    chk("sr_abort_n", ab_n - a0, 1);
    chk("sr_abort_lat", ab_cyc - s, 1);
    chk("sr_ov", ab_ov, 0);
    chk("sr_perr", perr_n - pe0, 0);
    expb(0, 1, 0, 8'h0C); expb(0, 0, 0, 8'hA1);
    expb(1, 1, 0, 8'h05); expb(1, 0, 0, 8'h77); expb(1, 0, 1, 8'h72);
    cmp_stream("sr", base);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
